// File: rtl/dmi_arbiter_if.sv
// Bundle of requester-side and core-side DMI handshake signals around dmi_arbiter.
// Requests pack as {addr[6:0], op[1:0], data[31:0]}; responses pack as {data[31:0], resp[1:0]}.
interface dmi_arbiter_if #(
  parameter int unsigned NumReq = 2
);
  logic [NumReq-1:0]       req_valid_i;
  logic [NumReq-1:0]       req_ready_o;
  logic [NumReq-1:0][40:0] req_i;
  logic [NumReq-1:0]       resp_valid_o;
  logic [NumReq-1:0]       resp_ready_i;
  logic [33:0]             resp_o;
  logic [40:0]             core_dmi_req_o;
  logic                    core_dmi_valid_o;
  logic                    core_dmi_ready_i;
  logic [33:0]             core_dmi_resp_i;
  logic                    core_dmi_valid_i;
  logic                    core_dmi_ready_o;
  logic                    busy_o;

  modport slave (
    input  req_valid_i, req_i, resp_ready_i,
           core_dmi_ready_i, core_dmi_resp_i, core_dmi_valid_i,
    output req_ready_o, resp_valid_o, resp_o,
           core_dmi_req_o, core_dmi_valid_o, core_dmi_ready_o, busy_o
  );

  modport master (
    output req_valid_i, req_i, resp_ready_i,
           core_dmi_ready_i, core_dmi_resp_i, core_dmi_valid_i,
    input  req_ready_o, resp_valid_o, resp_o,
           core_dmi_req_o, core_dmi_valid_o, core_dmi_ready_o, busy_o
  );
endinterface

// File: rtl/dmi_arbiter.sv
// Round-robin arbiter sharing one DMI channel among NumReq requesters, one transaction at a time.
// Optional response watchdog: define DMI_ARBITER_TIMEOUT_EN.
module dmi_arbiter #(
  parameter int unsigned NumReq        = 2,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  dmi_arbiter_if.slave   bus
);

  localparam int unsigned PtrW    = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam logic [PtrW-1:0] LastIdx = PtrW'(NumReq - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP, RETURN} state_e;

  state_e           state_q, state_d;
  logic [PtrW-1:0]  ptr_q, owner_q, win;
  logic             win_found, accept, resp_take, timeout;
  logic [40:0]      req_q;
  logic [33:0]      resp_q;

  always_comb begin
    win_found = 1'b0;
    win       = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      int unsigned idx;
      idx = (32'(ptr_q) + i) % NumReq;
      if (!win_found && bus.req_valid_i[PtrW'(idx)]) begin
        win_found = 1'b1;
        win       = PtrW'(idx);
      end
    end
  end

  // Reset gates the grant so req_ready_o stays low while rst_ni is asserted.
  assign accept    = (state_q == IDLE) && win_found && rst_ni;
  assign resp_take = (state_q == WAIT_RESP) && bus.core_dmi_valid_i;

`ifdef DMI_ARBITER_TIMEOUT_EN
  logic [15:0] cnt_q;

  assign timeout = ((state_q == ISSUE) || (state_q == WAIT_RESP)) &&
                   (cnt_q == 16'(TimeoutCycles - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= '0;
    end else if ((state_q == ISSUE) || (state_q == WAIT_RESP)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d              = state_q;
    bus.req_ready_o      = '0;
    bus.resp_valid_o     = '0;
    bus.core_dmi_valid_o = 1'b0;
    bus.core_dmi_ready_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          bus.req_ready_o[win] = 1'b1;
          state_d              = ISSUE;
        end
      end
      ISSUE: begin
        // A handshake completing on the watchdog's last cycle still wins.
        bus.core_dmi_valid_o = 1'b1;
        if (bus.core_dmi_ready_i) begin
          state_d = WAIT_RESP;
        end else if (timeout) begin
          state_d = RETURN;
        end
      end
      WAIT_RESP: begin
        bus.core_dmi_ready_o = 1'b1;
        if (bus.core_dmi_valid_i || timeout) begin
          state_d = RETURN;
        end
      end
      RETURN: begin
        bus.resp_valid_o[owner_q] = 1'b1;
        if (bus.resp_ready_i[owner_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      req_q   <= '0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        req_q   <= bus.req_i[win];
        owner_q <= win;
        ptr_q   <= (win == LastIdx) ? '0 : win + 1'b1;
      end
      if (resp_take) begin
        resp_q <= bus.core_dmi_resp_i;
      end else if (timeout && (state_d == RETURN)) begin
        resp_q <= {32'h0, 2'h2};
      end
    end
  end

  assign bus.core_dmi_req_o = req_q;
  assign bus.resp_o         = resp_q;
  assign bus.busy_o         = (state_q != IDLE);

endmodule

// File: tb/tb_dmi_arbiter.sv
// Directed plus randomized checks of dmi_arbiter against a round-robin transaction model.
module tb_dmi_arbiter;

  localparam int unsigned N = 2;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int unsigned mptr;

  dmi_arbiter_if #(.NumReq(N)) bus ();

  dmi_arbiter #(.NumReq(N), .TimeoutCycles(8)) u_dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=no_finish expected=finish");
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Round-robin rule: first valid requester at or above the pointer, wrapping.
  function automatic int unsigned pick(input logic [1:0] m);
    for (int unsigned k = 0; k < N; k++) begin
      int unsigned idx;
      idx = (mptr + k) % N;
      if (((m >> idx) & 2'b01) != 2'b00) return idx;
    end
    return 0;
  endfunction

  task automatic run_txn(input logic [1:0] vmask, input logic [1:0] later_mask,
                         input logic [40:0] r0, input logic [40:0] r1,
                         input int unsigned rdy_dly, input int unsigned resp_dly,
                         input int unsigned rr_dly, input logic [33:0] cresp);
    int unsigned w;
    logic [40:0] exp_req;
    logic [1:0]  own;
    w   = pick(vmask);
    own = 2'b01 << w;
    exp_req = (w == 1) ? r1 : r0;
    bus.req_valid_i = vmask;
    bus.req_i[0]    = r0;
    bus.req_i[1]    = r1;
    #1;
    chk("grant", 64'(bus.req_ready_o), 64'(own));
    chk("idle_busy", 64'(bus.busy_o), 64'd0);
    mptr = (w + 1) % N;
    step();
    bus.req_valid_i = later_mask;
    #1;
    for (int unsigned i = 0; i < rdy_dly; i++) begin
      chk("issue_valid", 64'(bus.core_dmi_valid_o), 64'd1);
      chk("issue_req", 64'(bus.core_dmi_req_o), 64'(exp_req));
      chk("issue_noready", 64'(bus.req_ready_o), 64'd0);
      step();
      #1;
    end
    bus.core_dmi_ready_i = 1'b1;
    #1;
    chk("issue_valid", 64'(bus.core_dmi_valid_o), 64'd1);
    chk("issue_req", 64'(bus.core_dmi_req_o), 64'(exp_req));
    chk("issue_busy", 64'(bus.busy_o), 64'd1);
    step();
    bus.core_dmi_ready_i = 1'b0;
    #1;
    chk("wait_novalid", 64'(bus.core_dmi_valid_o), 64'd0);
    chk("wait_ready", 64'(bus.core_dmi_ready_o), 64'd1);
    for (int unsigned i = 0; i < resp_dly; i++) begin
      step();
      #1;
      chk("wait_ready", 64'(bus.core_dmi_ready_o), 64'd1);
    end
    bus.core_dmi_valid_i = 1'b1;
    bus.core_dmi_resp_i  = cresp;
    step();
    bus.core_dmi_valid_i = 1'b0;
    bus.core_dmi_resp_i  = 34'($urandom);
    bus.resp_ready_i     = ~own;
    #1;
    for (int unsigned k = 0; k <= rr_dly; k++) begin
      chk("ret_valid", 64'(bus.resp_valid_o), 64'(own));
      chk("ret_data", 64'(bus.resp_o), 64'(cresp));
      chk("ret_noreq", 64'(bus.req_ready_o), 64'd0);
      chk("ret_nocore", 64'(bus.core_dmi_ready_o), 64'd0);
      if (k < rr_dly) begin
        step();
        #1;
      end
    end
    bus.resp_ready_i = 2'b11;
    #1;
    chk("ret_valid", 64'(bus.resp_valid_o), 64'(own));
    step();
    bus.resp_ready_i = 2'b00;
  endtask

  initial begin
    int unsigned n;
    checks   = 0;
    failures = 0;
    mptr     = 0;
    rst_n    = 1'b0;
    bus.req_valid_i      = 2'b11;
    bus.req_i[0]         = '0;
    bus.req_i[1]         = '0;
    bus.resp_ready_i     = '0;
    bus.core_dmi_ready_i = 1'b0;
    bus.core_dmi_resp_i  = '0;
    bus.core_dmi_valid_i = 1'b0;
    #2;
    chk("rst_req_ready", 64'(bus.req_ready_o), 64'd0);
    chk("rst_resp_valid", 64'(bus.resp_valid_o), 64'd0);
    chk("rst_core_valid", 64'(bus.core_dmi_valid_o), 64'd0);
    chk("rst_core_ready", 64'(bus.core_dmi_ready_o), 64'd0);
    chk("rst_core_req", 64'(bus.core_dmi_req_o), 64'd0);
    chk("rst_resp", 64'(bus.resp_o), 64'd0);
    chk("rst_busy", 64'(bus.busy_o), 64'd0);
    bus.req_valid_i = 2'b00;
    step();
    step();
    rst_n = 1'b1;

    // Single read of 0x11 by requester 0.
    run_txn(2'b01, 2'b00, {7'h11, 2'd1, 32'h0}, '0, 0, 0, 0, {32'hDEADBEEF, 2'd0});

    // Both requesters held valid: alternating grants.
    for (int t = 0; t < 4; t++) begin
      run_txn(2'b11, 2'b11, {7'(t), 2'd2, $urandom}, {7'(t + 8), 2'd1, $urandom},
              0, 1, 0, {$urandom, 2'(t)});
    end

    // Core stalls 5 cycles in ISSUE.
    run_txn(2'b01, 2'b00, {7'h22, 2'd2, 32'hCAFE0001}, '0, 5, 0, 0, {32'h12345678, 2'd0});

    // Owner 0 stalls 3 cycles in RETURN while requester 1 waits; 1 then wins at once.
    run_txn(2'b01, 2'b10, {7'h33, 2'd1, 32'h0}, {7'h44, 2'd1, 32'h0}, 0, 0, 3, {32'hA5A5A5A5, 2'd0});
    run_txn(2'b10, 2'b00, '0, {7'h44, 2'd1, 32'h0}, 1, 0, 0, {32'h5A5A5A5A, 2'd3});

    // Reset while waiting for the core response.
    bus.req_valid_i = 2'b01;
    #1;
    chk("grant", 64'(bus.req_ready_o), 64'(2'b01 << pick(2'b01)));
    mptr = (pick(2'b01) + 1) % N;
    step();
    bus.req_valid_i      = 2'b11;
    bus.core_dmi_ready_i = 1'b1;
    step();
    bus.core_dmi_ready_i = 1'b0;
    #1;
    chk("wait_ready", 64'(bus.core_dmi_ready_o), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_req_ready", 64'(bus.req_ready_o), 64'd0);
    chk("mid_rst_core_ready", 64'(bus.core_dmi_ready_o), 64'd0);
    chk("mid_rst_core_valid", 64'(bus.core_dmi_valid_o), 64'd0);
    chk("mid_rst_resp_valid", 64'(bus.resp_valid_o), 64'd0);
    chk("mid_rst_busy", 64'(bus.busy_o), 64'd0);
    step();
    rst_n = 1'b1;
    mptr  = 0;
    run_txn(2'b11, 2'b00, {7'h01, 2'd1, 32'h0}, {7'h02, 2'd1, 32'h0}, 0, 0, 0, {32'h0BADF00D, 2'd0});

    // Randomized traffic against the model.
    for (int t = 0; t < 12; t++) begin
      run_txn(2'($urandom_range(1, 3)), 2'($urandom_range(0, 3)),
              41'({$urandom, $urandom}), 41'({$urandom, $urandom}),
              $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2),
              34'({$urandom, $urandom}));
    end

    // Core accepts the request but never responds.
    bus.req_valid_i = 2'b01;
    #1;
    chk("grant", 64'(bus.req_ready_o), 64'(2'b01 << pick(2'b01)));
    mptr = (pick(2'b01) + 1) % N;
    step();
    bus.req_valid_i      = 2'b00;
    bus.core_dmi_ready_i = 1'b1;
    step();
    bus.core_dmi_ready_i = 1'b0;
    #1;
    n = 1;
    while (bus.resp_valid_o == 2'b00 && n < 30) begin
      step();
      #1;
      n++;
    end
`ifdef DMI_ARBITER_TIMEOUT_EN
    chk("to_latency", 64'(n), 64'd8);
    chk("to_valid", 64'(bus.resp_valid_o), 64'(2'b01));
    chk("to_resp", 64'(bus.resp_o), 64'h2);
    chk("to_nocore", 64'(bus.core_dmi_ready_o), 64'd0);
    bus.core_dmi_valid_i = 1'b1;
    bus.core_dmi_resp_i  = {32'hFFFFFFFF, 2'd0};
    bus.resp_ready_i     = 2'b01;
    step();
    bus.resp_ready_i = 2'b00;
    #1;
    chk("to_busy_clear", 64'(bus.busy_o), 64'd0);
    chk("to_late_ignored", 64'(bus.core_dmi_ready_o), 64'd0);
    bus.core_dmi_valid_i = 1'b0;
`else
    chk("no_to_busy", 64'(bus.busy_o), 64'd1);
    chk("no_to_valid", 64'(bus.resp_valid_o), 64'd0);
    chk("no_to_wait", 64'(bus.core_dmi_ready_o), 64'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    mptr  = 0;
`endif
    run_txn(2'b11, 2'b00, {7'h55, 2'd1, 32'h0}, {7'h66, 2'd1, 32'h0}, 0, 0, 0, {32'h600DCAFE, 2'd0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
